// File: rtl/sr_latch_pkg.sv
// Shared types and defaults for the gated SR latch monitor.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN,
        ST_SETTLE,
        ST_CHECK,
        ST_INVALID
    } state_t;

    localparam int SETTLE_DEFAULT = 2;
    localparam int ERR_W_DEFAULT  = 8;
    localparam int SETTLE_MAX     = 15;
    localparam int SETTLE_CNT_W   = 4;

endpackage

// File: rtl/sr_latch_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sr_latch_monitor.sv
// Tracks the expected state of a gated SR latch and flags output mismatches once inputs settle.
// Optional feature: define SR_LATCH_MONITOR_STICKY_EN to build the err_sticky flag register.
module sr_latch_monitor
    import sr_latch_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT,
    parameter int ERR_W  = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic             r,
    input  logic             e,
    input  logic             q,
    input  logic             notq,
    input  logic             clear,
    output logic             exp_q,
    output logic             valid,
    output logic             err,
    output logic             forbid,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_sticky
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    exp_next;
    logic [SETTLE_CNT_W-1:0] cnt;
    logic [SETTLE_CNT_W-1:0] cnt_next;
    logic [2:0]              prev_sre;
    logic                    err_next;
    logic                    forbid_next;
    logic                    changed;
    logic                    forbidden;
    logic                    defined;
    logic                    mismatch;

    assign changed   = ({s, r, e} != prev_sre);
    assign forbidden = e & s & r;
    assign defined   = e & (s ^ r);
    assign mismatch  = (q != exp_q) || (notq != ~exp_q);
    assign valid     = (state == ST_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_UNKNOWN;
            exp_q    <= 1'b0;
            cnt      <= '0;
            prev_sre <= '0;
            err      <= 1'b0;
            forbid   <= 1'b0;
        end else begin
            state    <= state_next;
            exp_q    <= exp_next;
            cnt      <= cnt_next;
            prev_sre <= {s, r, e};
            err      <= err_next;
            forbid   <= forbid_next;
        end
    end

    // Forbidden input overrides every state; otherwise any s/r/e change re-arms the settle window.
    always_comb begin
        state_next  = state;
        exp_next    = defined ? s : exp_q;
        cnt_next    = cnt;
        err_next    = 1'b0;
        forbid_next = 1'b0;
        if (forbidden) begin
            state_next  = ST_INVALID;
            forbid_next = (state != ST_INVALID);
            cnt_next    = '0;
        end else begin
            case (state)
                ST_UNKNOWN, ST_INVALID: begin
                    if (defined) begin
                        state_next = ST_SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (changed) begin
                        cnt_next = SETTLE_LOAD;
                    end else if (cnt == '0) begin
                        state_next = ST_CHECK;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (changed) begin
                        state_next = ST_SETTLE;
                        cnt_next   = SETTLE_LOAD;
                    end else begin
                        err_next = mismatch;
                    end
                end
                default: state_next = ST_UNKNOWN;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err),
        .clr  (clear),
        .count(err_cnt)
    );

`ifdef SR_LATCH_MONITOR_STICKY_EN
    logic sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (clear) begin
            sticky <= 1'b0;
        end else if (err) begin
            sticky <= 1'b1;
        end
    end

    assign err_sticky = sticky;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Scoreboard bench for sr_latch_monitor: random and directed stimulus against a stability-based reference model.
module tb_sr_latch_monitor;

    localparam int SETTLE  = 3;
    localparam int ERR_W   = 2;
    localparam int CNT_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s = 1'b0, r = 1'b0, e = 1'b0, q = 1'b0, notq = 1'b1, clear = 1'b0;
    logic             exp_q, valid, err, forbid, err_sticky;
    logic [ERR_W-1:0] err_cnt;

    typedef struct {
        bit valid;
        bit exp_q;
        bit err;
        bit forbid;
        bit sticky;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the latch value is known after a defined command, and checking
    // is active once the inputs have stayed unchanged for SETTLE edges.
    bit       m_known, m_invalid, m_exp, m_valid, m_err, m_forbid, m_sticky;
    int       m_since, m_cnt;
    bit [2:0] m_prev;

    sr_latch_monitor #(
        .SETTLE(SETTLE),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .r         (r),
        .e         (e),
        .q         (q),
        .notq      (notq),
        .clear     (clear),
        .exp_q     (exp_q),
        .valid     (valid),
        .err       (err),
        .forbid    (forbid),
        .err_cnt   (err_cnt),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_known = 0; m_invalid = 0; m_exp = 0; m_valid = 0; m_err = 0;
        m_forbid = 0; m_sticky = 0; m_since = 0; m_cnt = 0; m_prev = '0;
    endtask

    task automatic apply_stimulus(input bit si, input bit ri, input bit ei,
                                  input bit qi, input bit nqi, input bit clri);
        bit   chg, forb, def, n_err;
        exp_t x;
        @(negedge clk);
        s = si; r = ri; e = ei; q = qi; notq = nqi; clear = clri;
        chg   = ({si, ri, ei} != m_prev);
        forb  = ei && si && ri;
        def   = ei && (si != ri);
        n_err = m_valid && !chg && ((qi != m_exp) || (nqi == m_exp));
        if (clri) m_cnt = 0;
        else if (m_err && m_cnt < CNT_MAX) m_cnt++;
`ifdef SR_LATCH_MONITOR_STICKY_EN
        if (clri) m_sticky = 0;
        else if (m_err) m_sticky = 1;
`else
        m_sticky = 0;
`endif
        m_forbid = forb && !m_invalid;
        m_since  = chg ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
        if (forb) begin
            m_known = 0; m_invalid = 1;
        end else if (def) begin
            m_known = 1; m_invalid = 0; m_exp = si;
        end
        m_valid = m_known && (m_since >= SETTLE);
        m_err   = n_err;
        m_prev  = {si, ri, ei};
        x = '{valid: m_valid, exp_q: m_exp, err: m_err, forbid: m_forbid, sticky: m_sticky, cnt: m_cnt};
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_output("reset valid", valid, 0);
        check_output("reset exp_q", exp_q, 0);
        check_output("reset err", err, 0);
        check_output("reset forbid", forbid, 0);
        check_output("reset err_cnt", err_cnt, 0);
        check_output("reset err_sticky", err_sticky, 0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per cycle the DUT has produced a response for.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check_output("valid", valid, x.valid);
                check_output("exp_q", exp_q, x.exp_q);
                check_output("err", err, x.err);
                check_output("forbid", forbid, x.forbid);
                check_output("err_cnt", err_cnt, x.cnt);
                check_output("err_sticky", err_sticky, x.sticky);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pick, len, k;
        bit si, ri, ei, qi, nqi;
        model_reset();
        do_reset();

        for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 1, 1, 0);

        apply_stimulus(1, 0, 1, 1, 0, 1);
        for (int i = 0; i < SETTLE + 2; i++) apply_stimulus(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) apply_stimulus(1, 0, 1, 1, 0, 0);
        @(posedge clk);
        #2 check_output("directed err_cnt after 3 mismatches", err_cnt, 3);

        for (int i = 0; i < 6; i++) apply_stimulus(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < SETTLE + 2; i++) apply_stimulus(0, 1, 1, 0, 1, 0);

        for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 1, 1, 0, 0);
        @(posedge clk);
        #2 check_output("directed err_cnt saturated", err_cnt, CNT_MAX);
        apply_stimulus(0, 1, 1, 0, 1, 1);
        @(posedge clk);
        #2 check_output("directed err_cnt clear wins", err_cnt, 0);

        for (int i = 0; i < 10; i++) apply_stimulus(i[0] ? 1'b0 : 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < SETTLE + 3; i++) apply_stimulus(1, 0, 1, 1, 0, 0);
        @(posedge clk);
        #2 check_output("directed valid before reset", valid, m_valid);
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, i[0], 0, 0, 0);

        for (int seg = 0; seg < 600; seg++) begin
            pick = $urandom_range(0, 9);
            len  = $urandom_range(1, SETTLE + 4);
            case (pick)
                0, 1, 2: begin si = 1; ri = 0; ei = 1; end
                3, 4, 5: begin si = 0; ri = 1; ei = 1; end
                6:       begin si = 0; ri = 0; ei = 1; end
                7:       begin si = 1'($urandom); ri = 1'($urandom); ei = 0; end
                8:       begin si = 1; ri = 1; ei = 1; end
                default: begin si = 1'($urandom); ri = 1'($urandom); ei = 1'($urandom); end
            endcase
            for (int c = 0; c < len; c++) begin
                qi  = m_exp;
                nqi = !m_exp;
                if ($urandom_range(0, 9) == 0) begin
                    k   = $urandom_range(1, 3);
                    qi  = qi ^ k[0];
                    nqi = nqi ^ k[1];
                end
                apply_stimulus(si, ri, ei, qi, nqi, $urandom_range(0, 29) == 0);
            end
            if (seg == 300) do_reset();
        end

        @(posedge clk);
        #2 check_output("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
